// File: rtl/haze_pkg.sv
// haze_pkg
//   Shared constants for the haze-removal scene recovery datapath and the
//   reciprocal helper used to fill the reciprocal ROM.
//   recip_val(tc, maxv, frac) = round(maxv * 2^frac / tc).
//   It returns 0 for tc = 0; that entry is never addressed because tc is floored.
package haze_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int MAXV_DEF    = (1 << DATA_W_DEF) - 1;
  localparam int T_MIN_DEF   = 26;
  localparam int RECIP_F_DEF = 8;

  function automatic int unsigned recip_val(input int unsigned tc,
                                            input int unsigned maxv,
                                            input int unsigned frac);
    if (tc == 0) return 0;
    return ((maxv << frac) + (tc >> 1)) / tc;
  endfunction

endpackage

// File: rtl/recip_lut.sv
// recip_lut
//   Registered reciprocal ROM with MAXV+1 entries, indexed by the floored
//   transmission tc. The register loads only while en_i is high, so the ROM
//   output holds together with the rest of the pipeline during a stall.
//   clk_i  in   clock
//   en_i   in   load enable (pipeline advance)
//   tc_i   in   floored transmission, DATA_W bits
//   r_o    out  round(MAXV*2^RECIP_F / tc), RECIP_W bits, MSB always 0
module recip_lut import haze_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RECIP_F = RECIP_F_DEF,
  parameter int RECIP_W = 13
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [DATA_W-1:0]  tc_i,
  output logic [RECIP_W-1:0] r_o
);

  localparam int MAXV = (1 << DATA_W) - 1;

  logic [RECIP_W-1:0] rom [0:MAXV];

  // Entries below the transmission floor are unreachable; they are allowed
  // to truncate.
  for (genvar i = 0; i <= MAXV; i++) begin : g_rom
    assign rom[i] = RECIP_W'(recip_val(i, MAXV, RECIP_F));
  end

  always_ff @(posedge clk_i) begin
    if (en_i) r_o <= rom[tc_i];
  end

endmodule

// File: rtl/scene_recovery_pipe.sv
// scene_recovery_pipe
//   Pipelined multi-channel haze-removal scene reconstruction:
//     J_c = A_c + (I_c - A_c) * MAXV / max(t, T_MIN)
//   The result is rounded half up and saturated to 0..MAXV. In bypass, J = I.
//   There are three register stages and a single global advance. Bubbles are
//   kept, and valid bits travel with the data.
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (clears valids and outputs)
//   in_valid   in   input beat valid
//   in_ready   out  beat accepted when in_valid & in_ready
//   in_pix     in   hazy pixel I, channel c at [c*DATA_W +: DATA_W]
//   in_atm     in   atmospheric light A per channel
//   in_t       in   transmission t, shared by all channels
//   in_last    in   end-of-line marker
//   bypass     in   1 -> out_pix = in_pix for this beat
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts
//   out_pix    out  recovered pixel J
//   out_last   out  delayed in_last
module scene_recovery_pipe import haze_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHANNELS = 3,
  parameter int T_MIN    = T_MIN_DEF,
  parameter int RECIP_F  = RECIP_F_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_pix,
  input  logic [CHANNELS*DATA_W-1:0]   in_atm,
  input  logic [DATA_W-1:0]            in_t,
  input  logic                         in_last,
  input  logic                         bypass,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_pix,
  output logic                         out_last
);

  localparam int MAXV    = (1 << DATA_W) - 1;
  localparam int RECIP_W = $clog2(MAXV * (1 << RECIP_F) / T_MIN + 1) + 1;
  localparam int P_W     = DATA_W + 1 + RECIP_W;
  localparam int Q_W     = P_W + 1 - RECIP_F;
  localparam int S_W     = Q_W + 1;
  localparam logic signed [P_W:0] HALF = (P_W+1)'(1 << (RECIP_F - 1));

  // Round half up: add half an LSB, then drop the fraction arithmetically.
  function automatic logic signed [Q_W-1:0] round_q(input logic signed [P_W-1:0] p);
    logic signed [P_W:0] t;
    t = (P_W+1)'(p) + HALF;
    return Q_W'(t >>> RECIP_F);
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic signed [S_W-1:0] s);
    if (s[S_W-1]) return '0;
    if (s > S_W'(MAXV)) return DATA_W'(MAXV);
    return s[DATA_W-1:0];
  endfunction

  logic advance;
  logic vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0] tc;
  logic [RECIP_W-1:0] r_p0;
  logic [CHANNELS*DATA_W-1:0] i_p0, a_p0, i_p1, a_p1;
  logic byp_p0, byp_p1, last_p0, last_p1;
  logic [CHANNELS*DATA_W-1:0] pix_d, out_pix_q;
  logic out_last_q;

  // A stall freezes every stage at once, including the ROM register.
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = vld_p2;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

  // t below the floor (including t = 0) is treated as T_MIN.
  assign tc = (in_t < DATA_W'(T_MIN)) ? DATA_W'(T_MIN) : in_t;

  // ---- stage 1: reciprocal lookup, per-channel difference ----
  recip_lut #(
    .DATA_W (DATA_W),
    .RECIP_F(RECIP_F),
    .RECIP_W(RECIP_W)
  ) u_lut (
    .clk_i(clock),
    .en_i (advance),
    .tc_i (tc),
    .r_o  (r_p0)
  );

  always_ff @(posedge clock) begin
    if (advance) begin
      i_p0    <= in_pix;
      a_p0    <= in_atm;
      byp_p0  <= bypass;
      last_p0 <= in_last;
      // ---- stage 2 ----
      i_p1    <= i_p0;
      a_p1    <= a_p0;
      byp_p1  <= byp_p0;
      last_p1 <= last_p0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [DATA_W:0]  d_p0;
    logic signed [P_W-1:0]   p_p1;
    logic signed [S_W-1:0]   s;

    always_ff @(posedge clock) begin
      if (advance) begin
        d_p0 <= signed'({1'b0, in_pix[c*DATA_W +: DATA_W]})
              - signed'({1'b0, in_atm[c*DATA_W +: DATA_W]});
        // ---- stage 2: scale the difference by the reciprocal ----
        p_p1 <= P_W'(d_p0) * P_W'(signed'({1'b0, r_p0}));
      end
    end

    // ---- stage 3 input: round, re-add A, saturate ----
    assign s = S_W'(signed'({1'b0, a_p1[c*DATA_W +: DATA_W]})) + S_W'(round_q(p_p1));
    assign pix_d[c*DATA_W +: DATA_W] = byp_p1 ? i_p1[c*DATA_W +: DATA_W] : sat_pix(s);
  end

  // ---- stage 3: output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_pix_q  <= '0;
      out_last_q <= 1'b0;
    end else if (advance) begin
      vld_p0     <= in_valid;
      vld_p1     <= vld_p0;
      vld_p2     <= vld_p1;
      out_pix_q  <= pix_d;
      out_last_q <= last_p1;
    end
  end

endmodule
